axi4l_slave_to_wishbone: RTL
============================

AXI4L_SLAVE_TO_WISHBONE -- requirements
Module: axi4l_slave_to_wishbone

Interface
REQ-001 The block SHALL have parameter AXI4L_ADDR_WIDTH, default 40, AXI4-Lite byte-address width.
REQ-002 The block SHALL have parameter AXI4L_DATA_SIZE, default 3, log2 of the data width in bytes (3 = 64 bit).
REQ-003 The block SHALL have parameter WB_ADR_WIDTH, default AXI4L_ADDR_WIDTH-AXI4L_DATA_SIZE, Wishbone word-address width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 255, Wishbone ack timeout in clocks; 0 disables the timeout.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; the ports are:
  reset  in  1  asynchronous active-high reset
  clk  in  1  single clock for the AXI4-Lite and Wishbone sides
  s_axi4l_awaddr/awprot/awvalid  in  ADDR/3/1; s_axi4l_awready  out  1
  s_axi4l_wdata/wstrb/wvalid  in  DATA/DATA/8/1; s_axi4l_wready  out  1
  s_axi4l_bresp/bvalid  out  2/1; s_axi4l_bready  in  1
  s_axi4l_araddr/arprot/arvalid  in  ADDR/3/1; s_axi4l_arready  out  1
  s_axi4l_rdata/rresp/rvalid  out  DATA/2/1; s_axi4l_rready  in  1
  m_wb_adr_o  out  WB_ADR_WIDTH  word address
  m_wb_dat_o / m_wb_dat_i  out / in  DATA  write / read data
  m_wb_sel_o  out  DATA/8  byte select
  m_wb_we_o / m_wb_stb_o  out  1  write enable / strobe
  m_wb_ack_i  in  1  acknowledge

Function
REQ-006 The AW, W and AR channels SHALL each have a one-entry holding slot; awready, wready and arready SHALL equal the inverse of the corresponding slot-full flag (combinational).
REQ-007 AW and W SHALL be accepted independently in any order or in the same cycle.
REQ-008 A write SHALL become eligible once both the AW and W slots are full; a read SHALL become eligible once the AR slot is full.
REQ-009 The FSM SHALL have the states IDLE, WB_WR, WB_RD, B_RESP and R_RESP.
REQ-010 In IDLE, when both a write and a read are eligible, the grant SHALL alternate round-robin, with write having priority after reset.
REQ-011 The strobe SHALL assert one clock after grant (registered) and SHALL hold with stable adr, dat, sel and we until ack or timeout.
REQ-012 m_wb_adr_o SHALL equal addr[ADDR-1:AXI4L_DATA_SIZE].
REQ-013 A write SHALL drive sel = wstrb and dat_o = wdata; a read SHALL drive sel = all ones and we = 0.
REQ-014 On ack, stb SHALL fall on the next clock, the same clock SHALL raise bvalid/rvalid with resp 2'b00, rdata SHALL be captured from m_wb_dat_i in the ack cycle, and the used slots SHALL be freed.
REQ-015 The timeout counter SHALL start at stb rise; after TIMEOUT_CYCLES clocks with no ack, stb SHALL fall and the response SHALL be SLVERR (2'b10) with rdata 0.
REQ-016 When ack coincides with the timeout cycle, ack SHALL win (OKAY).
REQ-017 bvalid/rvalid SHALL hold with stable payload until ready; the FSM SHALL return to IDLE after the handshake.
REQ-018 No new Wishbone cycle SHALL start while a response is pending; slots MAY refill during this time.
REQ-019 awprot/arprot SHALL be ignored.
REQ-020 With ack returned in the first stb cycle, latency SHALL be AW+W accept at N, stb at N+1, ack at N+1, bvalid at N+2.

Reset
REQ-021 While reset is high, all slots SHALL be empty (awready = wready = arready = 1).
REQ-022 While reset is high: stb, we, bvalid and rvalid SHALL be 0; bresp, rresp, rdata, adr, dat and sel SHALL be 0; FSM = IDLE; round-robin flag = write; timeout counter = 0.
REQ-023 Assertion of reset mid-transaction SHALL drop stb and bvalid/rvalid immediately, and the pending transaction SHALL be discarded.

Structure
REQ-024 A shared package SHALL hold the resp constants (OKAY = 2'b00, SLVERR = 2'b10) and the FSM state enum.
REQ-025 The one-entry slot SHALL be a sub-module, axi4l_hold_slot (parameterised width, valid/ready in, full/data out, clear in), instantiated three times.

Verification
REQ-026 Write 0x10 with data 0x1122334455667788 and wstrb 0xFF, ack after 3 clocks -> adr 0x2, sel 0xFF, we 1; bresp 00, bvalid 1 clock after ack.
REQ-027 W presented 2 clocks before AW, wstrb 0x0F -> stb asserts only after AW is accepted; sel 0x0F.
REQ-028 Read 0x18 with ack and dat_i 0xDEADBEEF -> rdata 0xDEADBEEF, rresp 00; rready held low for 5 clocks -> rvalid and rdata stable.
REQ-029 Write and read eligible in the same cycle, twice -> order W, R, then R, W.
REQ-030 TIMEOUT_CYCLES = 4 with no ack -> stb high for exactly 4 clocks, bresp 10; ack in the 4th clock -> bresp 00.
REQ-031 Reset asserted during stb -> stb 0 asynchronously; after release, all readies are 1 and the next write completes normally.

Source files
------------

// File: rtl/axi4l_slave_to_wishbone_pkg.sv
// Shared definitions for the AXI4-Lite slave to Wishbone master bridge:
// response codes and the bridge FSM state encoding.
package axi4l_slave_to_wishbone_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WB_WR,
        WB_RD,
        B_RESP,
        R_RESP
    } wb_state_t;

endpackage

// File: rtl/axi4l_hold_slot.sv
// One-entry holding slot for an AXI4-Lite request channel. It captures the
// payload when valid arrives while empty and stays full until cleared.
module axi4l_hold_slot
    import axi4l_slave_to_wishbone_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (valid && !full_q) begin
            full_d = 1'b1;
            data_d = data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule

// File: rtl/axi4l_slave_to_wishbone.sv
// AXI4-Lite slave that turns each read or write into a single classic
// Wishbone cycle, with round-robin arbitration and an optional ack timeout.
module axi4l_slave_to_wishbone
    import axi4l_slave_to_wishbone_pkg::*;
#(
    parameter int AXI4L_ADDR_WIDTH = 40,
    parameter int AXI4L_DATA_SIZE  = 3,
    parameter int WB_ADR_WIDTH     = AXI4L_ADDR_WIDTH - AXI4L_DATA_SIZE,
    parameter int TIMEOUT_CYCLES   = 255,
    localparam int DATA_W          = 8 << AXI4L_DATA_SIZE,
    localparam int STRB_W          = DATA_W / 8
) (
    input  logic                        reset,
    input  logic                        clk,
    input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_awaddr,
    input  logic [2:0]                  s_axi4l_awprot,
    input  logic                        s_axi4l_awvalid,
    output logic                        s_axi4l_awready,
    input  logic [DATA_W-1:0]           s_axi4l_wdata,
    input  logic [STRB_W-1:0]           s_axi4l_wstrb,
    input  logic                        s_axi4l_wvalid,
    output logic                        s_axi4l_wready,
    output logic [1:0]                  s_axi4l_bresp,
    output logic                        s_axi4l_bvalid,
    input  logic                        s_axi4l_bready,
    input  logic [AXI4L_ADDR_WIDTH-1:0] s_axi4l_araddr,
    input  logic [2:0]                  s_axi4l_arprot,
    input  logic                        s_axi4l_arvalid,
    output logic                        s_axi4l_arready,
    output logic [DATA_W-1:0]           s_axi4l_rdata,
    output logic [1:0]                  s_axi4l_rresp,
    output logic                        s_axi4l_rvalid,
    input  logic                        s_axi4l_rready,
    output logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o,
    output logic [DATA_W-1:0]           m_wb_dat_o,
    input  logic [DATA_W-1:0]           m_wb_dat_i,
    output logic [STRB_W-1:0]           m_wb_sel_o,
    output logic                        m_wb_we_o,
    output logic                        m_wb_stb_o,
    input  logic                        m_wb_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic                          aw_full, w_full, ar_full;
    logic                          aw_clr, w_clr, ar_clr;
    logic [AXI4L_ADDR_WIDTH-1:0]   aw_data, ar_data;
    logic [DATA_W+STRB_W-1:0]      w_data;
    logic [AXI4L_ADDR_WIDTH-1:0]   aw_addr_eff, ar_addr_eff;
    logic [DATA_W+STRB_W-1:0]      w_eff;
    logic                          wr_elig, rd_elig, grant_wr;
    logic                          timeout_hit, wb_done;
    logic                          unused_prot;

    wb_state_t                     state_q, state_d;
    logic                          rr_read_q, rr_read_d;
    logic                          stb_q, stb_d;
    logic                          we_q, we_d;
    logic [WB_ADR_WIDTH-1:0]       adr_q, adr_d;
    logic [DATA_W-1:0]             dat_q, dat_d;
    logic [STRB_W-1:0]             sel_q, sel_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          rvalid_q, rvalid_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic [DATA_W-1:0]             rdata_q, rdata_d;
    logic [CNT_W-1:0]              tmo_cnt_q, tmo_cnt_d;

    assign unused_prot = ^{s_axi4l_awprot, s_axi4l_arprot};

    axi4l_hold_slot #(.WIDTH(AXI4L_ADDR_WIDTH)) u_aw_slot (
        .clk     (clk),
        .reset   (reset),
        .valid   (s_axi4l_awvalid),
        .data_in (s_axi4l_awaddr),
        .clear   (aw_clr),
        .full    (aw_full),
        .data    (aw_data)
    );

    axi4l_hold_slot #(.WIDTH(DATA_W + STRB_W)) u_w_slot (
        .clk     (clk),
        .reset   (reset),
        .valid   (s_axi4l_wvalid),
        .data_in ({s_axi4l_wstrb, s_axi4l_wdata}),
        .clear   (w_clr),
        .full    (w_full),
        .data    (w_data)
    );

    axi4l_hold_slot #(.WIDTH(AXI4L_ADDR_WIDTH)) u_ar_slot (
        .clk     (clk),
        .reset   (reset),
        .valid   (s_axi4l_arvalid),
        .data_in (s_axi4l_araddr),
        .clear   (ar_clr),
        .full    (ar_full),
        .data    (ar_data)
    );

    assign s_axi4l_awready = ~aw_full;
    assign s_axi4l_wready  = ~w_full;
    assign s_axi4l_arready = ~ar_full;

    // An empty slot forwards the request being accepted this cycle, so the
    // strobe can rise on the clock right after the handshake.
    assign aw_addr_eff = aw_full ? aw_data : s_axi4l_awaddr;
    assign w_eff       = w_full  ? w_data  : {s_axi4l_wstrb, s_axi4l_wdata};
    assign ar_addr_eff = ar_full ? ar_data : s_axi4l_araddr;

    assign wr_elig  = (aw_full | s_axi4l_awvalid) & (w_full | s_axi4l_wvalid);
    assign rd_elig  = ar_full | s_axi4l_arvalid;
    assign grant_wr = wr_elig & (~rd_elig | ~rr_read_q);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign wb_done     = m_wb_ack_i | timeout_hit;

    always_comb begin
        state_d   = state_q;
        rr_read_d = rr_read_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        tmo_cnt_d = tmo_cnt_q;
        aw_clr    = 1'b0;
        w_clr     = 1'b0;
        ar_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                // The fairness flag only moves when both sides contend.
                if (wr_elig && rd_elig) begin
                    rr_read_d = ~rr_read_q;
                end
                if (grant_wr) begin
                    state_d = WB_WR;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = WB_ADR_WIDTH'(aw_addr_eff >> AXI4L_DATA_SIZE);
                    dat_d   = w_eff[DATA_W-1:0];
                    sel_d   = w_eff[DATA_W+STRB_W-1:DATA_W];
                end else if (rd_elig) begin
                    state_d = WB_RD;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = WB_ADR_WIDTH'(ar_addr_eff >> AXI4L_DATA_SIZE);
                    sel_d   = '1;
                end
            end
            WB_WR: begin
                if (wb_done) begin
                    state_d   = B_RESP;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    tmo_cnt_d = '0;
                    bvalid_d  = 1'b1;
                    bresp_d   = m_wb_ack_i ? RESP_OKAY : RESP_SLVERR;
                    aw_clr    = 1'b1;
                    w_clr     = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            WB_RD: begin
                if (wb_done) begin
                    state_d   = R_RESP;
                    stb_d     = 1'b0;
                    tmo_cnt_d = '0;
                    rvalid_d  = 1'b1;
                    rresp_d   = m_wb_ack_i ? RESP_OKAY : RESP_SLVERR;
                    rdata_d   = m_wb_ack_i ? m_wb_dat_i : '0;
                    ar_clr    = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            B_RESP: begin
                if (s_axi4l_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            R_RESP: begin
                if (s_axi4l_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_read_q <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_read_q <= rr_read_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign m_wb_stb_o     = stb_q;
    assign m_wb_we_o      = we_q;
    assign m_wb_adr_o     = adr_q;
    assign m_wb_dat_o     = dat_q;
    assign m_wb_sel_o     = sel_q;
    assign s_axi4l_bvalid = bvalid_q;
    assign s_axi4l_bresp  = bresp_q;
    assign s_axi4l_rvalid = rvalid_q;
    assign s_axi4l_rresp  = rresp_q;
    assign s_axi4l_rdata  = rdata_q;

endmodule
